fetch_unit: RTL and testbench

Instruction fetch stage of the RV32IMF pipeline, directly upstream of the decode stage. Holds the PC, issues in-order requests to instruction memory over a valid/ready request channel, buffers returned words in a small FIFO, and presents one instruction plus its PC per cycle to decode. A redirect from execute (taken branch or jump) flushes the FIFO and all in-flight responses and restarts fetch at the target.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch: PC, in-order imem requests, response FIFO, redirect flush.
// Optional: define FETCH_MISALIGN_CHECK_EN to flag and halt on misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        fetch_misalign
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    // Stale responses can pile up across back-to-back redirects, so this is wider than CW.
    localparam int DW = CW + 4;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   fifo_word [QDEPTH];
    logic [31:0]   fifo_pc   [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] qcount;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] drop_cnt;
    logic          halted;
    logic          pop;
    logic          req_fire;
    logic          rsp_keep;
    logic          push;
    logic [CW:0]   credit_used;
    logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect) begin
            misalign_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted         = misalign_q;
    assign fetch_misalign = misalign_q;
`else
    logic unused_low_bits;

    assign unused_low_bits = ^redirect_pc[1:0];
    assign halted          = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    assign target_pc   = {redirect_pc[31:2], 2'b00};
    assign instr_valid = (qcount != '0);
    assign instruction = instr_valid ? fifo_word[rd_ptr] : NOP;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0;
    assign pop         = instr_valid && !stall;

    // Credit covers live in-flight requests plus queued words, so a response always has a slot.
    assign credit_used    = {1'b0, outstanding} + {1'b0, qcount} - {{CW{1'b0}}, pop};
    assign imem_req_valid = !redirect && !halted && (credit_used < DEPTH_L);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0);
    assign push           = rsp_keep && !redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            qcount      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            // Everything still in flight, minus a response consumed this cycle, becomes stale.
            pc          <= target_pc;
            rsp_pc      <= target_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            qcount      <= '0;
            outstanding <= '0;
            drop_cnt    <= drop_cnt + DW'(outstanding) - DW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            qcount      <= qcount + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[wr_ptr] <= imem_rsp_data;
            fifo_pc[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against an epoch-tagged memory/FIFO model.
module tb_fetch_unit;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        fetch_misalign;

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ent_t;

    mreq_t       memq[$];
    ent_t        mfifo[$];
    int          epoch;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          npop;
    logic        halted;
    logic [31:0] exp_req_pc;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        #1;
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instruction", instruction, NOP);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_misalign", fetch_misalign, 1'b0);
        memq.delete();
        mfifo.delete();
        epoch = 0;
        halted = 1'b0;
        exp_req_pc = RPC;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, compare every output to the model, advance the model.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st, input logic rdy);
        logic  pop;
        logic  exp_req;
        int    live;
        mreq_t e;
        redirect = rd; redirect_pc = rpc; stall = st; imem_req_ready = rdy;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        pop  = (mfifo.size() > 0) && !st;
        live = mfifo.size();
        foreach (memq[i]) if (memq[i].epoch == epoch) live++;
        exp_req = !rd && !halted && ((live - int'(pop)) < QD);
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, exp_req_pc);
        check("instr_valid", instr_valid, mfifo.size() > 0);
        check("instr_pc", instr_pc, (mfifo.size() > 0) ? mfifo[0].pc : 32'h0);
        check("instruction", instruction, (mfifo.size() > 0) ? mfifo[0].word : NOP);
        check("misalign", fetch_misalign, halted);
        e = '{addr: 32'h0, epoch: -1, due: 0};
        if (imem_rsp_valid) e = memq.pop_front();
        if (rd) begin
            epoch++;
            mfifo.delete();
            exp_req_pc = {rpc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
            halted = (rpc[1:0] != 2'b00);
`else
            halted = 1'b0;
`endif
        end else begin
            if (pop) begin
                void'(mfifo.pop_front());
                npop++;
            end
            if (imem_rsp_valid && e.epoch == epoch)
                mfifo.push_back('{pc: e.addr, word: mem_word(e.addr)});
            if (exp_req && rdy) begin
                memq.push_back('{addr: exp_req_pc, epoch: epoch,
                                 due: cyc + int'($urandom_range(lat_max, lat_min))});
                exp_req_pc = exp_req_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] hp;
        int          n;
        vectors = 0; miscompares = 0; npop = 0;
        rst = 1'b0;
        lat_min = 1; lat_max = 1;
        do_reset();

        // Start-up latency and sustained throughput with a 1-cycle memory.
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("first_valid", instr_valid, 1'b1);
        check("first_pc", instr_pc, RPC);
        npop = 0;
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("throughput", npop, 10);

        // Memory not ready: address and valid held.
        cycle(1'b1, 32'h400, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_addr", imem_req_addr, 32'h400);
        check("hold_valid", imem_req_valid, 1'b1);

        // Decode stall: head held, requests stop at credit limit, no loss after release.
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        hp = instr_pc;
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("stall_head", instr_pc, hp);
        check("stall_req", imem_req_valid, 1'b0);
        repeat (12) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Latency 3, redirect with two requests outstanding.
        lat_min = 3; lat_max = 3;
        cycle(1'b1, 32'h500, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h200, 1'b0, 1'b1);
        n = 0;
        while (!instr_valid && n < 20) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            n++;
        end
        check("redir_first_pc", instr_pc, 32'h200);

        // Redirect coinciding with a response and a pop in a streaming pipe.
        lat_min = 1; lat_max = 1;
        cycle(1'b1, 32'h600, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h700, 1'b0, 1'b1);
        check("flush_empty", instr_valid, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("redir_t3_valid", instr_valid, 1'b1);
        check("redir_t3_pc", instr_pc, 32'h700);

        // Misaligned redirect target.
        cycle(1'b1, 32'h202, 1'b0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_flag", fetch_misalign, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("mis_halt", imem_req_valid, 1'b0);
        cycle(1'b1, 32'h300, 1'b0, 1'b1);
        check("mis_clear", fetch_misalign, 1'b0);
        check("mis_resume", imem_req_addr, 32'h300);
`else
        check("mis_flag", fetch_misalign, 1'b0);
        check("mis_align_addr", imem_req_addr, 32'h200);
`endif
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Randomized traffic: variable latency, backpressure, stalls, redirects.
        lat_min = 1; lat_max = 3;
        repeat (600) begin
            cycle(($urandom_range(0, 19) == 0), $urandom_range(0, 16383),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end

        // Reset mid-traffic, then resume from RESET_PC.
        do_reset();
        repeat (20) cycle(1'b0, 32'h0, ($urandom_range(0, 3) == 0), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
